// File: rtl/fpu_align_pipe.sv
// FPU alignment stage: orders operands by magnitude, aligns the smaller mantissa with GRS bits, folds sub into add, forms the mul exponent.
// Latency: 1 cycle from input transfer to out_valid; full throughput.
// Backpressure: one-entry skid buffer absorbs a beat during an output stall; in_ready is registered and drops while the skid is occupied.
module fpu_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int GRS_W = 3,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign_1,
  input  logic               in_sign_2,
  input  logic [EXP_W-1:0]   in_exponent_1,
  input  logic [EXP_W-1:0]   in_exponent_2,
  input  logic [MAN_W-1:0]   in_mantissa_1,
  input  logic [MAN_W-1:0]   in_mantissa_2,
  input  logic [1:0]         in_operator,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sign_1,
  output logic               sign_2,
  output logic [EXP_W+1:0]   exponent,
  output logic [MAN_W+GRS_W-1:0] mantissa_1,
  output logic [MAN_W+GRS_W-1:0] mantissa_2,
  output logic [1:0]         operator,
  output logic               swapped
);

  // Extended mantissa width and signed exponent width.
  localparam int W  = MAN_W + GRS_W;
  localparam int XW = EXP_W + 2;

  localparam logic [XW-1:0] BIAS_X = XW'(BIAS);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // One complete output beat; the output register and the skid buffer both hold this.
  typedef struct packed {
    logic           sign_1;
    logic           sign_2;
    logic [XW-1:0]  exponent;
    logic [W-1:0]   mantissa_1;
    logic [W-1:0]   mantissa_2;
    logic [1:0]     operator;
    logic           swapped;
  } beat_t;

  // Datapath intermediates.
  logic             sign_2_eff;
  logic             do_swap;
  logic             sign_big;
  logic             sign_small;
  logic [EXP_W-1:0] exp_big;
  logic [EXP_W-1:0] exp_small;
  logic [MAN_W-1:0] man_big;
  logic [MAN_W-1:0] man_small;
  logic [EXP_W-1:0] shift_d;
  logic [31:0]      shift_wide;
  logic [W-1:0]     ext_small;
  logic [W-1:0]     shifted;
  logic             lost_bits;
  logic [W-1:0]     aligned_small;
  logic [XW-1:0]    mul_exp;
  beat_t            comp;

  // Handshake state.
  beat_t            out_q;
  logic             out_valid_q;
  beat_t            skid_q;
  logic             skid_valid;
  logic             skid_valid_next;
  logic             in_ready_q;
  logic             accept;
  logic             drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_ready || !out_valid_q;

  // Magnitude ordering and right alignment of the smaller operand with sticky collapse.
  always_comb begin
    sign_2_eff = in_sign_2 ^ (in_operator == OP_SUB);
    do_swap    = (in_exponent_2 > in_exponent_1) ||
                 ((in_exponent_2 == in_exponent_1) && (in_mantissa_2 > in_mantissa_1));

    if (do_swap) begin
      sign_big   = sign_2_eff;
      sign_small = in_sign_1;
      exp_big    = in_exponent_2;
      exp_small  = in_exponent_1;
      man_big    = in_mantissa_2;
      man_small  = in_mantissa_1;
    end else begin
      sign_big   = in_sign_1;
      sign_small = sign_2_eff;
      exp_big    = in_exponent_1;
      exp_small  = in_exponent_2;
      man_big    = in_mantissa_1;
      man_small  = in_mantissa_2;
    end

    shift_d    = exp_big - exp_small;
    shift_wide = {{(32-EXP_W){1'b0}}, shift_d};
    ext_small  = {man_small, {GRS_W{1'b0}}};
    shifted    = '0;
    lost_bits  = 1'b0;

    // A shift past the whole extended field leaves only the sticky bit.
    if (shift_wide >= 32'(W)) begin
      aligned_small = {{(W-1){1'b0}}, |man_small};
    end else begin
      shifted       = ext_small >> shift_d;
      lost_bits     = |(ext_small & ~({W{1'b1}} << shift_d));
      aligned_small = shifted | {{(W-1){1'b0}}, lost_bits};
    end
  end

  // Biased product exponent; wraps in XW bits so over/underflow stays visible downstream.
  always_comb begin
    mul_exp = {2'b00, in_exponent_1} + {2'b00, in_exponent_2} - BIAS_X;
  end

  // Assemble the beat for the selected operator.
  always_comb begin
    comp = '0;
    case (in_operator)
      OP_ADD, OP_SUB: begin
        comp.sign_1     = sign_big;
        comp.sign_2     = sign_small;
        comp.exponent   = {2'b00, exp_big};
        comp.mantissa_1 = {man_big, {GRS_W{1'b0}}};
        comp.mantissa_2 = aligned_small;
        comp.operator   = OP_ADD;
        comp.swapped    = do_swap;
      end
      OP_MUL: begin
        comp.sign_1     = in_sign_1;
        comp.sign_2     = in_sign_2;
        comp.exponent   = mul_exp;
        comp.mantissa_1 = {in_mantissa_1, {GRS_W{1'b0}}};
        comp.mantissa_2 = {in_mantissa_2, {GRS_W{1'b0}}};
        comp.operator   = OP_MUL;
        comp.swapped    = 1'b0;
      end
      default: begin
        comp.sign_1   = in_sign_1;
        comp.sign_2   = in_sign_2;
        comp.operator = OP_RSV;
      end
    endcase
  end

  // Skid occupancy: fills on accept during a stall, empties when the output drains.
  always_comb begin
    skid_valid_next = skid_valid;
    if (drain && skid_valid) begin
      skid_valid_next = 1'b0;
    end else if (!drain && accept) begin
      skid_valid_next = 1'b1;
    end
  end

  // Output register, skid buffer and registered in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (drain) begin
        if (skid_valid) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= accept;
          if (accept) begin
            out_q <= comp;
          end
        end
      end else if (accept) begin
        skid_q <= comp;
      end
      skid_valid <= skid_valid_next;
      in_ready_q <= !skid_valid_next;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign sign_1     = out_q.sign_1;
  assign sign_2     = out_q.sign_2;
  assign exponent   = out_q.exponent;
  assign mantissa_1 = out_q.mantissa_1;
  assign mantissa_2 = out_q.mantissa_2;
  assign operator   = out_q.operator;
  assign swapped    = out_q.swapped;

endmodule

// File: tb/tb_fpu_align_pipe.sv
// Directed bench for fpu_align_pipe: hand-computed vectors for add/sub/mul/reserved, backpressure and reset.
// Outputs sampled 1 time unit after the rising edge; inputs driven on the falling edge.
// Backpressure exercised by holding out_ready low while streaming three beats.
module tb_fpu_align_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign_1, in_sign_2;
  logic [7:0]  in_exponent_1, in_exponent_2;
  logic [23:0] in_mantissa_1, in_mantissa_2;
  logic [1:0]  in_operator;
  logic        out_valid;
  logic        out_ready;
  logic        sign_1, sign_2;
  logic [9:0]  exponent;
  logic [26:0] mantissa_1, mantissa_2;
  logic [1:0]  operator;
  logic        swapped;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_align_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign_1(in_sign_1), .in_sign_2(in_sign_2),
    .in_exponent_1(in_exponent_1), .in_exponent_2(in_exponent_2),
    .in_mantissa_1(in_mantissa_1), .in_mantissa_2(in_mantissa_2),
    .in_operator(in_operator),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_1(sign_1), .sign_2(sign_2),
    .exponent(exponent),
    .mantissa_1(mantissa_1), .mantissa_2(mantissa_2),
    .operator(operator), .swapped(swapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic s1, input logic [7:0] e1, input logic [23:0] m1,
                        input logic s2, input logic [7:0] e2, input logic [23:0] m2,
                        input logic [1:0] op);
    in_sign_1 = s1; in_exponent_1 = e1; in_mantissa_1 = m1;
    in_sign_2 = s2; in_exponent_2 = e2; in_mantissa_2 = m2;
    in_operator = op;
  endtask

  // One beat through an unstalled pipe, then a full field compare.
  task automatic run_vec(input string tag,
                         input logic s1, input logic [7:0] e1, input logic [23:0] m1,
                         input logic s2, input logic [7:0] e2, input logic [23:0] m2,
                         input logic [1:0] op,
                         input logic xs1, input logic xs2, input logic [9:0] xexp,
                         input logic [26:0] xm1, input logic [26:0] xm2,
                         input logic [1:0] xop, input logic xsw);
    @(negedge clk);
    set_in(s1, e1, m1, s2, e2, m2, op);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".sign_1"}, 64'(sign_1), 64'(xs1));
    check({tag, ".sign_2"}, 64'(sign_2), 64'(xs2));
    check({tag, ".exponent"}, 64'(exponent), 64'(xexp));
    check({tag, ".mantissa_1"}, 64'(mantissa_1), 64'(xm1));
    check({tag, ".mantissa_2"}, 64'(mantissa_2), 64'(xm2));
    check({tag, ".operator"}, 64'(operator), 64'(xop));
    check({tag, ".swapped"}, 64'(swapped), 64'(xsw));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 24'd0, 2'b00);
    #12;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.exponent", 64'(exponent), 64'd0);
    check("rst.mantissa_1", 64'(mantissa_1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle.out_valid", 64'(out_valid), 64'd0);

    run_vec("add", 0, 8'd130, 24'hC00000, 0, 8'd128, 24'h800000, 2'b00,
            0, 0, 10'd130, 27'h6000000, 27'h1000000, 2'b00, 0);
    // Beat drains with out_ready high and nothing new arrives.
    @(posedge clk); #1;
    check("add.drain", 64'(out_valid), 64'd0);

    run_vec("sub_swap", 0, 8'd127, 24'h800000, 0, 8'd129, 24'hA00000, 2'b01,
            1, 0, 10'd129, 27'h5000000, 27'h1000000, 2'b00, 1);
    run_vec("sticky25", 0, 8'd145, 24'h800000, 0, 8'd120, 24'h800001, 2'b00,
            0, 0, 10'd145, 27'h4000000, 27'h0000003, 2'b00, 0);
    run_vec("sticky30", 0, 8'd150, 24'h800000, 0, 8'd120, 24'h800001, 2'b00,
            0, 0, 10'd150, 27'h4000000, 27'h0000001, 2'b00, 0);
    run_vec("sticky30z", 0, 8'd150, 24'h800000, 0, 8'd120, 24'h000000, 2'b00,
            0, 0, 10'd150, 27'h4000000, 27'h0000000, 2'b00, 0);
    run_vec("eq_sub", 0, 8'd128, 24'h800000, 0, 8'd128, 24'h800000, 2'b01,
            0, 1, 10'd128, 27'h4000000, 27'h4000000, 2'b00, 0);
    run_vec("mul", 1, 8'd125, 24'hC00000, 0, 8'd130, 24'hA00000, 2'b10,
            1, 0, 10'd128, 27'h6000000, 27'h5000000, 2'b10, 0);
    run_vec("mul_uflow", 0, 8'd1, 24'h800000, 1, 8'd1, 24'h900000, 2'b10,
            0, 1, 10'h383, 27'h4000000, 27'h4800000, 2'b10, 0);
    run_vec("rsv", 1, 8'd5, 24'h123456, 1, 8'd7, 24'h654321, 2'b11,
            1, 1, 10'd0, 27'h0, 27'h0, 2'b11, 0);

    // Backpressure: A, B, C with output stalled.
    @(negedge clk);
    out_ready = 1'b0;
    set_in(0, 8'd100, 24'h800000, 0, 8'd90, 24'h800000, 2'b00);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp.A_out", 64'(exponent), 64'd100);
    check("bp.rdy_after_A", 64'(in_ready), 64'd1);
    @(negedge clk);
    set_in(0, 8'd101, 24'h800000, 0, 8'd90, 24'h800000, 2'b00);
    @(posedge clk); #1;
    check("bp.rdy_skid_full", 64'(in_ready), 64'd0);
    check("bp.A_hold1", 64'(exponent), 64'd100);
    @(negedge clk);
    set_in(0, 8'd102, 24'h800000, 0, 8'd90, 24'h800000, 2'b00);
    @(posedge clk); #1;
    check("bp.A_hold2", 64'(exponent), 64'd100);
    check("bp.valid_hold", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("bp.rdy_held", 64'(in_ready), 64'd0);
    check("bp.A_hold3", 64'(exponent), 64'd100);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.B_out", 64'(exponent), 64'd101);
    check("bp.rdy_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("bp.C_out", 64'(exponent), 64'd102);
    check("bp.C_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.empty", 64'(out_valid), 64'd0);

    // Reset mid-stream with output valid and skid full.
    @(negedge clk);
    out_ready = 1'b0;
    set_in(0, 8'd110, 24'h800000, 0, 8'd90, 24'h800000, 2'b00);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_in(0, 8'd111, 24'h800000, 0, 8'd90, 24'h800000, 2'b00);
    @(posedge clk); #1;
    check("mr.skid_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mr.out_valid", 64'(out_valid), 64'd0);
    check("mr.in_ready", 64'(in_ready), 64'd1);
    check("mr.exponent", 64'(exponent), 64'd0);
    check("mr.mantissa_2", 64'(mantissa_2), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mr.no_ghost", 64'(out_valid), 64'd0);
    run_vec("post_rst", 0, 8'd130, 24'hC00000, 0, 8'd128, 24'h800000, 2'b00,
            0, 0, 10'd130, 27'h6000000, 27'h1000000, 2'b00, 0);
    @(posedge clk); #1;
    check("post_rst.drain", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
